// File: rtl/alu_muldiv_stage.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One multiplier/quotient bit per cycle; divide-by-zero and signed overflow retire in one cycle.
`timescale 1ns/1ps
module alu_muldiv_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            prev_clk_en,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [4:0]      prev_rd,
   input  logic            prev_flush,
   input  logic            prev_stall,
   output logic            stall,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam int unsigned AW = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic            neg_res_q, neg_rem_q;
   logic [XLEN-1:0] opnd_q;
   logic [AW-1:0]   acc_q;

   logic            accept, a_sgn, b_sgn, a_neg, b_neg;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] a_mag, b_mag, fast_res;
   logic [XLEN:0]   mul_sum, rem_sh;
   logic            ge;
   logic [XLEN-1:0] rem_new, quo, rem;
   logic [AW-1:0]   acc_nxt, prod;
   logic [XLEN-1:0] final_res;

   // Operand decode: signedness, magnitudes and fast-path detection
   always_comb begin
      accept   = (state == S_IDLE) && start && prev_clk_en && !prev_flush;
      a_sgn    = ~funct3[0] | (funct3 == 3'd1);
      b_sgn    = a_sgn & (funct3 != 3'd2);
      a_neg    = a_sgn & operand_a[XLEN-1];
      b_neg    = b_sgn & operand_b[XLEN-1];
      a_mag    = a_neg ? -operand_a : operand_a;
      b_mag    = b_neg ? -operand_b : operand_b;
      div_zero = funct3[2] && (operand_b == '0);
      div_ovf  = funct3[2] && !funct3[0] && (operand_a == MIN_NEG) && (operand_b == '1);
      fast     = div_zero | div_ovf;
      if (div_zero) fast_res = funct3[1] ? operand_a : '1;
      else          fast_res = funct3[1] ? '0 : MIN_NEG;
   end

   // One iteration: shift-add for multiply, restoring shift-subtract for divide
   always_comb begin
      mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
      ge      = rem_sh >= {1'b0, opnd_q};
      rem_new = ge ? (rem_sh[XLEN-1:0] - opnd_q) : rem_sh[XLEN-1:0];
      acc_nxt = op_q[2] ? {rem_new, acc_q[XLEN-2:0], ge}
                        : {mul_sum, acc_q[XLEN-1:1]};
      prod    = neg_res_q ? -acc_nxt : acc_nxt;
      quo     = neg_res_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      rem     = neg_rem_q ? -acc_nxt[AW-1:XLEN] : acc_nxt[AW-1:XLEN];
      case (op_q)
         3'd0:          final_res = prod[XLEN-1:0];
         3'd4, 3'd5:    final_res = quo;
         3'd6, 3'd7:    final_res = rem;
         default:       final_res = prod[AW-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Flush dominates every transition
   always_comb begin
      state_nxt = state;
      if (prev_flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept)       state_nxt = fast ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt == '0)    state_nxt = S_DONE;
            S_DONE:  if (!prev_stall)  state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = 1'b0;
      result_valid = 1'b0;
      stall        = 1'b0;
      busy         = (state != S_IDLE);
      result_valid = (state == S_DONE);
      stall        = !prev_flush && (((state == S_IDLE) && start && prev_clk_en) ||
                                     (state == S_BUSY) ||
                                     ((state == S_DONE) && prev_stall));
   end

   // Datapath registers; result only ever written on a completing, unflushed edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt       <= '0;
         op_q      <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         result    <= '0;
         rd        <= '0;
      end else if (accept) begin
         op_q      <= funct3;
         rd        <= prev_rd;
         neg_res_q <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         opnd_q    <= funct3[2] ? b_mag : a_mag;
         acc_q     <= {XLEN'(0), (funct3[2] ? a_mag : b_mag)};
         cnt       <= CW'(XLEN - 1);
         if (fast) result <= fast_res;
      end else if ((state == S_BUSY) && !prev_flush) begin
         acc_q <= acc_nxt;
         cnt   <= cnt - CW'(1);
         if (cnt == '0) result <= final_res;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_stage.sv
// Scoreboard bench for alu_muldiv_stage: 64-bit reference model, latency/stall/hold checks.
`timescale 1ns/1ps
module tb_alu_muldiv_stage;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic        clk, rstn, start, prev_clk_en, prev_flush, prev_stall;
   logic [2:0]  funct3;
   logic [31:0] operand_a, operand_b, result;
   logic [4:0]  prev_rd, rd;
   logic        stall, busy, result_valid;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic rv_d = 1'b0;

   alu_muldiv_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rstn(rstn), .start(start), .prev_clk_en(prev_clk_en),
      .funct3(funct3), .operand_a(operand_a), .operand_b(operand_b),
      .prev_rd(prev_rd), .prev_flush(prev_flush), .prev_stall(prev_stall),
      .stall(stall), .busy(busy), .result_valid(result_valid),
      .result(result), .rd(rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic with RISC-V corner cases
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      logic [63:0] pv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = 0;
      case (f)
         3'd0, 3'd1: p = sa * sb;
         3'd2:       p = sa * ub;
         3'd3:       p = ua * ub;
         3'd4: p = (b == 0) ? -1 : (a == MIN_NEG && b == '1) ? sa : sa / sb;
         3'd5: p = (b == 0) ? -1 : ua / ub;
         3'd6: p = (b == 0) ? sa : (a == MIN_NEG && b == '1) ? 0 : sa % sb;
         default: p = (b == 0) ? ua : ua % ub;
      endcase
      pv = 64'(p);
      return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? pv[63:32] : pv[31:0];
   endfunction

   // Pop and compare on the first cycle of every DONE
   always @(negedge clk) begin
      if (!rstn) begin
         rv_d = 1'b0;
      end else begin
         if (result_valid && !rv_d) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_valid", 64'(result_valid), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_eq("result", 64'(result), 64'(e.res));
               check_eq("rd", 64'(rd), 64'(e.rd));
            end
         end
         rv_d = result_valid;
      end
   end

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input int hold);
      int   n, sc;
      logic fast;
      exp_t e;
      fast = f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == '1));
      @(negedge clk);
      start = 1'b1; funct3 = f; operand_a = a; operand_b = b; prev_rd = r;
      prev_stall = (hold > 0);
      e.res = model(f, a, b);
      e.rd  = r;
      exp_q.push_back(e);
      #1 sc = int'(stall);
      @(posedge clk); #1;
      n = 0;
      while (!result_valid && n < 4 * XLEN) begin
         sc += int'(stall);
         @(posedge clk); #1;
         n++;
      end
      check_eq("latency", 64'(n), fast ? 64'd0 : 64'(XLEN));
      check_eq("stall_cycles", 64'(sc), fast ? 64'd1 : 64'(XLEN + 1));
      start = 1'b0; operand_a = $urandom; operand_b = $urandom; prev_rd = 5'($urandom);
      for (int i = 0; i < hold; i++) begin
         check_eq("hold_valid", 64'(result_valid), 64'd1);
         check_eq("hold_result", 64'(result), 64'(e.res));
         check_eq("hold_stall", 64'(stall), 64'd1);
         if (i == hold - 1) prev_stall = 1'b0;
         @(posedge clk); #1;
      end
      if (hold == 0) begin
         check_eq("done_stall", 64'(stall), 64'd0);
         @(posedge clk); #1;
      end
      check_eq("to_idle", 64'({busy, result_valid}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; start = 1'b0; prev_clk_en = 1'b1; prev_flush = 1'b0; prev_stall = 1'b0;
      funct3 = '0; operand_a = '0; operand_b = '0; prev_rd = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_out", 64'({busy, result_valid, stall, rd, result}), 64'd0);
      rstn = 1'b1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 0);
      run_op(3'd1, MIN_NEG, MIN_NEG, 5'd1, 0);
      run_op(3'd3, MIN_NEG, MIN_NEG, 5'd2, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
      run_op(3'd5, 32'd100, 32'd7, 5'd6, 5);
      run_op(3'd7, 32'd100, 32'd7, 5'd7, 0);
      run_op(3'd4, 32'd5, 32'd0, 5'd8, 0);
      run_op(3'd6, 32'd5, 32'd0, 5'd9, 2);
      run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd10, 0);
      run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd12, 0);
      run_op(3'd5, 32'd9, 32'd0, 5'd13, 0);
      run_op(3'd5, MIN_NEG, 32'hFFFF_FFFF, 5'd14, 0);

      // Flush ten cycles into BUSY
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; operand_a = 32'd1234; operand_b = 32'd5678; prev_rd = 5'd20;
      @(posedge clk); #1 check_eq("flush_busy", 64'(busy), 64'd1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      prev_flush = 1'b1; start = 1'b0;
      #1 check_eq("flush_stall", 64'(stall), 64'd0);
      @(posedge clk); #1 check_eq("flush_idle", 64'({busy, result_valid}), 64'd0);
      prev_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_eq("flush_novalid", 64'(result_valid), 64'd0);
      run_op(3'd0, 32'd3, 32'd4, 5'd21, 0);

      // Flush on the final BUSY edge
      @(negedge clk);
      start = 1'b1; funct3 = 3'd5; operand_a = 32'd999; operand_b = 32'd3; prev_rd = 5'd22;
      @(posedge clk);
      repeat (XLEN - 1) @(posedge clk);
      @(negedge clk);
      check_eq("last_busy", 64'(busy), 64'd1);
      prev_flush = 1'b1; start = 1'b0;
      @(posedge clk); #1 check_eq("lastflush_idle", 64'({busy, result_valid}), 64'd0);
      prev_flush = 1'b0;

      // Flush together with start in IDLE; bubble in IDLE
      @(negedge clk);
      start = 1'b1; prev_flush = 1'b1;
      #1 check_eq("flushstart_stall", 64'(stall), 64'd0);
      @(posedge clk); #1 check_eq("flushstart_idle", 64'(busy), 64'd0);
      @(negedge clk);
      prev_flush = 1'b0; prev_clk_en = 1'b0;
      #1 check_eq("bubble_stall", 64'(stall), 64'd0);
      @(posedge clk); #1 check_eq("bubble_idle", 64'(busy), 64'd0);
      @(negedge clk);
      start = 1'b0; prev_clk_en = 1'b1;

      for (int i = 0; i < 16; i++) begin
         logic [31:0] b;
         b = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         run_op(3'($urandom_range(0, 7)), $urandom, b, 5'($urandom), i % 4);
      end

      // Async reset while BUSY
      @(negedge clk);
      start = 1'b1; funct3 = 3'd1; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678; prev_rd = 5'd30;
      repeat (6) @(posedge clk);
      #3 rstn = 1'b0; start = 1'b0;
      #1 check_eq("arst_out", 64'({busy, result_valid, stall, rd, result}), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1 check_eq("arst_idle", 64'({busy, result_valid}), 64'd0);
      run_op(3'd7, 32'hFFFF_FFF0, 32'd10, 5'd31, 0);

      repeat (2) @(negedge clk);
      check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
